// File: rtl/pixel_stream_gen_if.sv
// Bundle of the frame request, image-memory read port and pixel stream of pixel_stream_gen.
// The master side is the generator; the slave side is its environment.
`timescale 1ns/1ps
interface pixel_stream_gen_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic              busy;
   logic              done;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              ycbcr_hs;
   logic              ycbcr_de;
   logic [7:0]        ycbcr_pix;

   modport master (
      input  start, mem_data,
      output busy, done, mem_rd, mem_addr, ycbcr_hs, ycbcr_de, ycbcr_pix
   );

   modport slave (
      output start, mem_data,
      input  busy, done, mem_rd, mem_addr, ycbcr_hs, ycbcr_de, ycbcr_pix
   );
endinterface

// File: rtl/pixel_stream_gen.sv
// Reads a stored grey image in raster order and replays it as an hs/de/pixel line stream,
// followed by padding lines so downstream 3x3 windows can finish the bottom rows.
`timescale 1ns/1ps
module pixel_stream_gen #(
   parameter int         IMG_W     = 64,
   parameter int         IMG_H     = 64,
   parameter int         H_TAIL    = 3,
   parameter int         H_BLANK   = 4,
   parameter int         PAD_LINES = 1,
   parameter logic [7:0] PAD_VAL   = 8'd0,
   parameter int         ADDR_W    = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   pixel_stream_gen_if.master bus
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_ACT   = 3'd2,
      ST_TAIL  = 3'd3,
      ST_BLANK = 3'd4
   } state_t;

   localparam int CNT_MAX = (IMG_W > H_TAIL) ? ((IMG_W > H_BLANK) ? IMG_W : H_BLANK)
                                             : ((H_TAIL > H_BLANK) ? H_TAIL : H_BLANK);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ROWS    = IMG_H + PAD_LINES;
   localparam int ROW_W   = $clog2(ROWS + 1);

   localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(H_TAIL - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(H_BLANK - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_PAD    = ROW_W'(IMG_H);

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ROW_W-1:0]  row_r, row_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              rd_r, rd_s;

   logic              hs_int_s, de_int_s, pad_int_s;
   logic              hs_d1_r, de_d1_r, pad_d1_r;
   logic              hs_r, de_r;
   logic [7:0]        pix_r;

   // Next-state, counters, address and registered control outputs.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      row_s   = row_r;
      addr_s  = addr_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_LEAD;
               cnt_s   = '0;
               row_s   = '0;
               addr_s  = '0;
               busy_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LEAD: begin
            state_s = ST_ACT;
            cnt_s   = '0;
         end
         ST_ACT: begin
            if (row_r < ROW_PAD) begin
               addr_s = addr_r + ADDR_W'(1);
            end else begin
               addr_s = addr_r;
            end
            if (cnt_r == ACT_LAST) begin
               state_s = ST_TAIL;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
            end
         end
         ST_TAIL: begin
            if (cnt_r == TAIL_LAST) begin
               state_s = ST_BLANK;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
            end
         end
         ST_BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               cnt_s = '0;
               if (row_r == ROW_LAST) begin
                  state_s = ST_IDLE;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_LEAD;
                  row_s   = row_r + ROW_W'(1);
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            row_s   = '0;
            busy_s  = 1'b0;
         end
      endcase
      // Strobe is registered, so it is derived from where the FSM is going next.
      rd_s = (state_s == ST_ACT) && (row_s < ROW_PAD);
   end

   // FSM state, counters and control output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         row_r   <= '0;
         addr_r  <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rd_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         row_r   <= row_s;
         addr_r  <= addr_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         rd_r    <= rd_s;
      end
   end

   // Stream flags decoded from the current state.
   always_comb begin
      hs_int_s  = (state_r == ST_LEAD) || (state_r == ST_ACT) || (state_r == ST_TAIL);
      de_int_s  = (state_r == ST_ACT);
      pad_int_s = (row_r >= ROW_PAD);
   end

   // Two-stage flag delay so hs/de line up with the registered memory read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_d1_r  <= 1'b0;
         de_d1_r  <= 1'b0;
         pad_d1_r <= 1'b0;
         hs_r     <= 1'b0;
         de_r     <= 1'b0;
         pix_r    <= 8'd0;
      end else begin
         hs_d1_r  <= hs_int_s;
         de_d1_r  <= de_int_s;
         pad_d1_r <= pad_int_s;
         hs_r     <= hs_d1_r;
         de_r     <= de_d1_r;
         if (de_d1_r) begin
            pix_r <= pad_d1_r ? PAD_VAL : bus.mem_data;
         end else begin
            pix_r <= 8'd0;
         end
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.mem_rd    = rd_r;
   assign bus.mem_addr  = addr_r;
   assign bus.ycbcr_hs  = hs_r;
   assign bus.ycbcr_de  = de_r;
   assign bus.ycbcr_pix = pix_r;
endmodule
